// File: rtl/pad_sched_pkg.sv
// pad_sched_pkg: shared state type and width helpers for the padding-stage issue scheduler.
package pad_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int pix_total(input int size);
        return size * size;
    endfunction

    // One extra code so the pixel counter can step past the last pixel before DRAIN clears it.
    function automatic int pix_w(input int size);
        return $clog2(size * size + 1);
    endfunction

    function automatic int gap_w(input int interval);
        return (interval < 4) ? 1 : $clog2(interval - 2);
    endfunction

endpackage

// File: rtl/pad_sched_gap_timer.sv
// pad_sched_gap_timer: loadable down-counter that paces the GAP state; freeze stalls it.
module pad_sched_gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_freeze,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (!i_freeze && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_last = (r_cnt == W'(1)) && !i_freeze;

endmodule

// File: rtl/pad_sched.sv
// pad_sched: issues SIZE*SIZE feature-map pixels to the padding stage, INTERVAL cycles apart, per frame.
// Define PAD_SCHED_HOLD_EN to add a hold input that stretches the inter-pixel gap.
module pad_sched
    import pad_sched_pkg::*;
#(
    parameter int N        = 8,
    parameter int CHANNEL  = 3,
    parameter int SIZE     = 32,
    parameter int INTERVAL = 9,
    parameter int ADDR_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [7:0]             cfg_frames,
`ifdef PAD_SCHED_HOLD_EN
    input  logic                   hold,
`endif
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [CHANNEL*N-1:0]   mem_rdata,
    output logic                   pad_vld,
    output logic [CHANNEL*N-1:0]   pad_din,
    input  logic                   pad_end,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             frame_cnt
);

    localparam int PIX_TOTAL = pix_total(SIZE);
    localparam int PW        = pix_w(SIZE);
    localparam int GW        = gap_w(INTERVAL);

    if (INTERVAL < 3) begin : g_bad_interval
        $error("pad_sched: INTERVAL must be at least 3");
    end

    state_t               r_state, w_next;
    logic [ADDR_W-1:0]    r_ptr;
    logic [PW-1:0]        r_pix;
    logic [7:0]           r_frames;
    logic [7:0]           r_frame_cnt;
    logic                 r_seen_low;
    logic [CHANNEL*N-1:0] r_pad_din;
    logic                 w_hold, w_accept, w_fetch, w_last_pix, w_drain_ok, w_more, w_gap_last;

`ifdef PAD_SCHED_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // A new frame may only start fetching once padding reports it has drained.
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_fetch    = (r_state == S_FETCH) && !w_hold && (r_pix != '0 || pad_end);
    assign w_last_pix = r_pix == PW'(PIX_TOTAL - 1);
    assign w_drain_ok = (r_state == S_DRAIN) && r_seen_low && pad_end;
    assign w_more     = ({1'b0, r_frame_cnt} + 9'd1) < {1'b0, r_frames};

    pad_sched_gap_timer #(
        .W(GW)
    ) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (r_state == S_ISSUE),
        .i_load_val(GW'(INTERVAL - 3)),
        .i_freeze  (w_hold),
        .o_last    (w_gap_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        mem_rd  = w_fetch;
        pad_vld = r_state == S_ISSUE;
        done    = r_state == S_DONE;
        busy    = r_state != S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = w_fetch ? S_WAIT : S_FETCH;
            S_WAIT:  w_next = S_ISSUE;
            S_ISSUE: w_next = w_last_pix ? S_DRAIN : (INTERVAL == 3) ? S_FETCH : S_GAP;
            S_GAP:   w_next = w_gap_last ? S_FETCH : S_GAP;
            S_DRAIN: w_next = !w_drain_ok ? S_DRAIN : w_more ? S_FETCH : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_pix       <= '0;
            r_frames    <= '0;
            r_frame_cnt <= '0;
            r_seen_low  <= 1'b0;
            r_pad_din   <= '0;
        end else if (w_accept) begin
            r_ptr       <= cfg_base;
            r_frames    <= (cfg_frames == 8'd0) ? 8'd1 : cfg_frames;
            r_pix       <= '0;
            r_frame_cnt <= '0;
            r_seen_low  <= 1'b0;
        end else begin
            // seen_low proves padding actually consumed this frame before we trust pad_end again.
            if (busy && !pad_end)
                r_seen_low <= 1'b1;
            if (r_state == S_WAIT)
                r_pad_din <= mem_rdata;
            if (r_state == S_ISSUE) begin
                r_ptr <= r_ptr + ADDR_W'(1);
                r_pix <= r_pix + PW'(1);
            end
            if (w_drain_ok) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_pix       <= '0;
                r_seen_low  <= 1'b0;
            end
        end
    end

    assign mem_addr  = r_ptr;
    assign pad_din   = r_pad_din;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/pad_sched.md
# pad_sched

Feature-map issue scheduler for the `padding` stage of the CNN datapath. Reads SIZE×SIZE channel-packed pixels from the layer feature-map RAM and presents them to `padding` as single-cycle `input_vld` strobes spaced exactly INTERVAL cycles apart. After the last pixel it waits for `padding_dout_end` to confirm the padded frame has drained, then repeats for the configured number of frames and pulses `done`.

## Interface
- N, 8, bits per channel element
- CHANNEL, 3, channels packed per word
- SIZE, 32, unpadded frame edge length
- INTERVAL, 9, cycles between consecutive `pad_vld` strobes; must match downstream `CLK_INTERVAL`; elaboration error if < 3
- ADDR_W, 16, feature-map RAM address width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- cfg_base  in  ADDR_W  address of first pixel; latched on accepted start
- cfg_frames  in  8  frames to issue; latched on start; 0 treated as 1
- mem_rd  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  CHANNEL*N  RAM data, valid the cycle after `mem_rd`
- pad_vld  out  1  to `padding.input_vld`
- pad_din  out  CHANNEL*N  to `padding.input_din`
- pad_end  in  1  from `padding.padding_dout_end` (high = padding idle)
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle pulse at end of run
- frame_cnt  out  8  frames completed in current run

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, GAP, DRAIN, DONE.
- IDLE: on `start`, latch `cfg_base` into ptr and `cfg_frames` (0→1); clear pix, frame_cnt, seen_low; go to FETCH.
- FETCH: when pix==0, stall here until `pad_end`==1; otherwise assert `mem_rd` with `mem_addr`=ptr for one cycle and go to WAIT.
- WAIT: register `mem_rdata` into `pad_din`; go to ISSUE.
- ISSUE: `pad_vld`=1 for one cycle; ptr++, pix++. If pix was SIZE*SIZE−1, go to DRAIN; otherwise go to GAP (or straight to FETCH when INTERVAL==3).
- GAP: count INTERVAL−3 cycles, then go to FETCH.
- seen_low: sticky flag, set whenever `pad_end`==0 while busy; cleared at each frame start.
- DRAIN: wait until seen_low && `pad_end`==1. Then frame_cnt++, pix=0, clear seen_low. If frame_cnt+1 < frames, go to FETCH (ptr continues contiguously); else go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `pad_din` holds its last value between strobes. ptr wraps modulo 2^ADDR_W.
- Reset (any time, including mid-frame): all state clears immediately, state goes to IDLE. The `padding` block must be reset by the same `rst_n`.

## Timing
- Reset values: mem_rd=0, mem_addr=0, pad_vld=0, pad_din=0, busy=0, done=0, frame_cnt=0.
- Start sampled at edge k. busy=1 and mem_rd=1 in cycle k+1 (if pad_end=1). pad_vld=1 in cycle k+3.
- Within a frame, pad_vld strobes are exactly INTERVAL cycles apart; SIZE*SIZE strobes per frame.
- done is asserted one cycle after the DRAIN exit condition. busy falls the cycle after done.

## Configuration
- `PAD_SCHED_HOLD_EN` defined: adds input port `hold` (1 bit). While `hold`=1, the GAP counter freezes and FETCH does not issue `mem_rd`. A fetch already in flight (WAIT/ISSUE) completes. Spacing stretches by the number of held cycles.
- `PAD_SCHED_HOLD_EN` undefined: no `hold` port; strict INTERVAL pacing.

## Structure
- `pad_sched_pkg`: state enum type, `PIX_TOTAL = SIZE*SIZE` localparam helper, `pix_w`/`gap_w` clog2 width functions.
- One sub-module `pad_sched_gap_timer`: loadable down-counter with freeze input, used for GAP.

## Test plan
- SIZE=4, INTERVAL=9, cfg_base=0x10, cfg_frames=1, RAM[a]=a → 16 pad_vld strobes 9 cycles apart, pad_din 0x10..0x1F; with real `padding`, 36 padded outputs; done pulse once; frame_cnt=1.
- cfg_frames=0 → behaves as 1 frame; cfg_frames=3 → 48 strobes, addresses 0x10..0x3F, frame_cnt steps 1,2,3, single done.
- pad_end held 0 from the model before start → no mem_rd until pad_end=1; first pad_vld 2 cycles after pad_end rises.
- start pulsed again mid-frame → ignored; strobe count and addresses unchanged.
- rst_n low at strobe 7 → outputs reach reset values without waiting for a clock edge; new start after release restarts from cfg_base.
- With `PAD_SCHED_HOLD_EN`, hold high for 5 cycles during GAP → that strobe spacing is 14 cycles; all other spacings remain 9.
